bitwise_resp_checker: RTL and testbench

Synthesizable self-checking monitor for the 32-bit bitwise logic units (and/or/xor/nor). It receives the operand pairs applied to a unit under test and the unit's result. It computes the expected result internally and aligns it to the unit's latency with a valid-tagged delay pipe. It counts passes and failures and captures the first mismatch, so gate-level regressions and FPGA bring-up need no simulator `$monitor` inspection.

---
 rtl/bitwise_resp_checker_pkg.sv | 33 +++
 rtl/bitwise_resp_checker_pipe.sv | 82 ++++++++
 rtl/bitwise_resp_checker.sv | 193 +++++++++++++++++++
 tb/tb_bitwise_resp_checker.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitwise_resp_checker_pkg.sv
// ============================================================================
// bitwise_resp_checker_pkg : shared encodings for the bitwise response checker
// Rev 1.0
// ============================================================================
`default_nettype none

package bitwise_resp_checker_pkg;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10,
    DONE  = 2'b11
  } state_e;

  // Saturating increment keeps counters readable on very long runs.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bitwise_resp_checker_pipe.sv
// ============================================================================
// resp_delay_pipe : valid-tagged delay line aligning {a, b, exp} to unit latency
// Rev 1.0
// ============================================================================
`default_nettype none

module resp_delay_pipe #(
  parameter int WIDTH = 32,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_exp,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_exp
);

  generate
    if (LAT == 0) begin : g_bypass
      logic unused_pipe;
      assign unused_pipe = ^{clk, rst_n, flush};
      assign out_vld = in_vld;
      assign out_a   = in_a;
      assign out_b   = in_b;
      assign out_exp = in_exp;
    end else begin : g_stages
      logic [LAT-1:0]            vld_q, vld_d;
      logic [LAT-1:0][WIDTH-1:0] a_q, a_d;
      logic [LAT-1:0][WIDTH-1:0] b_q, b_d;
      logic [LAT-1:0][WIDTH-1:0] exp_q, exp_d;

      always_comb begin
        vld_d    = vld_q;
        a_d      = a_q;
        b_d      = b_q;
        exp_d    = exp_q;
        vld_d[0] = in_vld;
        a_d[0]   = in_a;
        b_d[0]   = in_b;
        exp_d[0] = in_exp;
        for (int i = 1; i < LAT; i++) begin
          vld_d[i] = vld_q[i-1];
          a_d[i]   = a_q[i-1];
          b_d[i]   = b_q[i-1];
          exp_d[i] = exp_q[i-1];
        end
        if (flush) begin
          vld_d = '0;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q <= '0;
        end else begin
          vld_q <= vld_d;
        end
      end

      // Payload is only meaningful alongside its valid bit, so it needs no reset.
      always_ff @(posedge clk) begin
        a_q   <= a_d;
        b_q   <= b_d;
        exp_q <= exp_d;
      end

      assign out_vld = vld_q[LAT-1];
      assign out_a   = a_q[LAT-1];
      assign out_b   = b_q[LAT-1];
      assign out_exp = exp_q[LAT-1];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/bitwise_resp_checker.sv
// ============================================================================
// bitwise_resp_checker : pass/fail monitor for 32-bit and/or/xor/nor units
// Rev 1.0
// ============================================================================
`default_nettype none

module bitwise_resp_checker
  import bitwise_resp_checker_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LAT     = 1,
  parameter int NUM_VEC = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] dut_z,
  output logic             busy,
  output logic             done,
  output logic [15:0]      pass_cnt,
  output logic [15:0]      fail_cnt,
  output logic             err_valid,
  output logic [WIDTH-1:0] err_a,
  output logic [WIDTH-1:0] err_b,
  output logic [WIDTH-1:0] err_exp,
  output logic [WIDTH-1:0] err_got
);

  localparam logic [CNT_W-1:0] LAST_VEC   = CNT_W'(NUM_VEC - 1);
  localparam logic [2:0]       DRAIN_LAST = 3'((LAT == 0) ? 0 : LAT - 1);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [CNT_W-1:0]  vec_cnt_q, vec_cnt_d;
  logic [2:0]        drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0]  pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0]  fail_cnt_q, fail_cnt_d;
  logic              err_valid_q, err_valid_d;
  logic [WIDTH-1:0]  err_a_q, err_a_d;
  logic [WIDTH-1:0]  err_b_q, err_b_d;
  logic [WIDTH-1:0]  err_exp_q, err_exp_d;
  logic [WIDTH-1:0]  err_got_q, err_got_d;

  logic              accept_start;
  logic              push;
  logic [WIDTH-1:0]  exp_val;
  logic              cmp_vld;
  logic              cmp_hit;
  logic [WIDTH-1:0]  cmp_a, cmp_b, cmp_exp;

  assign accept_start = start && ((state_q == IDLE) || (state_q == DONE));
  assign push         = (state_q == RUN) && in_valid;

  always_comb begin
    exp_val = '0;
    unique case (op_q)
      OP_AND:  exp_val = a & b;
      OP_OR:   exp_val = a | b;
      OP_XOR:  exp_val = a ^ b;
      OP_NOR:  exp_val = ~(a | b);
      default: exp_val = '0;
    endcase
  end

  resp_delay_pipe #(
    .WIDTH (WIDTH),
    .LAT   (LAT)
  ) u_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (accept_start),
    .in_vld  (push),
    .in_a    (a),
    .in_b    (b),
    .in_exp  (exp_val),
    .out_vld (cmp_vld),
    .out_a   (cmp_a),
    .out_b   (cmp_b),
    .out_exp (cmp_exp)
  );

  // Compares are only trusted while a run is live; DONE must hold results frozen.
  assign cmp_hit = cmp_vld && ((state_q == RUN) || (state_q == DRAIN));

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    vec_cnt_d   = vec_cnt_q;
    drain_cnt_d = drain_cnt_q;
    pass_cnt_d  = pass_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    err_valid_d = err_valid_q;
    err_a_d     = err_a_q;
    err_b_d     = err_b_q;
    err_exp_d   = err_exp_q;
    err_got_d   = err_got_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = RUN;
          op_d        = op_e'(op);
          vec_cnt_d   = '0;
          drain_cnt_d = '0;
          pass_cnt_d  = '0;
          fail_cnt_d  = '0;
          err_valid_d = 1'b0;
          err_a_d     = '0;
          err_b_d     = '0;
          err_exp_d   = '0;
          err_got_d   = '0;
        end
      end
      RUN: begin
        if (push) begin
          vec_cnt_d = vec_cnt_q + CNT_W'(1);
          if (vec_cnt_q == LAST_VEC) begin
            state_d     = (LAT == 0) ? DONE : DRAIN;
            drain_cnt_d = '0;
          end
        end
      end
      DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d = DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (cmp_hit) begin
      if (cmp_exp == dut_z) begin
        pass_cnt_d = sat_inc(pass_cnt_q);
      end else begin
        fail_cnt_d = sat_inc(fail_cnt_q);
        if (!err_valid_q) begin
          err_valid_d = 1'b1;
          err_a_d     = cmp_a;
          err_b_d     = cmp_b;
          err_exp_d   = cmp_exp;
          err_got_d   = dut_z;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= OP_AND;
      vec_cnt_q   <= '0;
      drain_cnt_q <= '0;
      pass_cnt_q  <= '0;
      fail_cnt_q  <= '0;
      err_valid_q <= 1'b0;
      err_a_q     <= '0;
      err_b_q     <= '0;
      err_exp_q   <= '0;
      err_got_q   <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      vec_cnt_q   <= vec_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      pass_cnt_q  <= pass_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      err_valid_q <= err_valid_d;
      err_a_q     <= err_a_d;
      err_b_q     <= err_b_d;
      err_exp_q   <= err_exp_d;
      err_got_q   <= err_got_d;
    end
  end

  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign pass_cnt  = pass_cnt_q;
  assign fail_cnt  = fail_cnt_q;
  assign err_valid = err_valid_q;
  assign err_a     = err_a_q;
  assign err_b     = err_b_q;
  assign err_exp   = err_exp_q;
  assign err_got   = err_got_q;

endmodule

`default_nettype wire

// File: tb/tb_bitwise_resp_checker.sv
// ============================================================================
// tb_bitwise_resp_checker : scoreboard bench over several LAT/NUM_VEC variants
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_bitwise_resp_checker;

  localparam int W  = 32;
  localparam int NI = 5;

  typedef struct {
    int         due;
    logic       ok;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] e;
    logic [W-1:0] g;
  } rec_t;

  logic         clk      = 1'b0;
  logic         rst_n    = 1'b0;
  logic         start    = 1'b0;
  logic         in_valid = 1'b0;
  logic [1:0]   op       = 2'b00;
  logic [W-1:0] a        = '0;
  logic [W-1:0] b        = '0;
  logic [W-1:0] mask     = '0;
  int           sel      = 0;
  int           cyc      = 0;
  int           last_cyc = 0;
  int           errors   = 0;
  int           checks   = 0;

  int           m_pass, m_fail;
  logic         m_ev;
  logic [W-1:0] m_ea, m_eb, m_ee, m_eg;
  rec_t         sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] ref_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    case (o)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return ~(x | y);
    endcase
  endfunction

  function automatic int lat_of(input int i);
    case (i)
      0:       return 0;
      1:       return 2;
      2:       return 1;
      3:       return 3;
      default: return 0;
    endcase
  endfunction

  function automatic int nv_of(input int i);
    return (i == 4) ? 1 : 9;
  endfunction

  // Behavioural unit under test: result of the current pair, optionally corrupted, delayed by LAT.
  logic [W-1:0] zcur;
  logic [W-1:0] zline [8];
  assign zcur = ref_op(op, a, b) ^ mask;
  always @(posedge clk) begin
    zline[0] <= zcur;
    for (int i = 1; i < 8; i++) zline[i] <= zline[i-1];
  end

  logic         busy_w [NI];
  logic         done_w [NI];
  logic         errv_w [NI];
  logic [15:0]  pass_w [NI];
  logic [15:0]  fail_w [NI];
  logic [W-1:0] ea_w [NI];
  logic [W-1:0] eb_w [NI];
  logic [W-1:0] ee_w [NI];
  logic [W-1:0] eg_w [NI];
  logic [W-1:0] dz_w [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int L = lat_of(g);
    if (L == 0) begin : g_comb
      assign dz_w[g] = zcur;
    end else begin : g_seq
      assign dz_w[g] = zline[L-1];
    end
    bitwise_resp_checker #(
      .WIDTH   (W),
      .LAT     (L),
      .NUM_VEC (nv_of(g))
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start && (sel == g)),
      .op        (op),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .dut_z     (dz_w[g]),
      .busy      (busy_w[g]),
      .done      (done_w[g]),
      .pass_cnt  (pass_w[g]),
      .fail_cnt  (fail_w[g]),
      .err_valid (errv_w[g]),
      .err_a     (ea_w[g]),
      .err_b     (eb_w[g]),
      .err_exp   (ee_w[g]),
      .err_got   (eg_w[g])
    );
  end

  logic         busy_s, done_s, errv_s;
  logic [15:0]  pass_s, fail_s;
  logic [W-1:0] ea_s, eb_s, ee_s, eg_s;
  assign busy_s = busy_w[sel];
  assign done_s = done_w[sel];
  assign errv_s = errv_w[sel];
  assign pass_s = pass_w[sel];
  assign fail_s = fail_w[sel];
  assign ea_s   = ea_w[sel];
  assign eb_s   = eb_w[sel];
  assign ee_s   = ee_w[sel];
  assign eg_s   = eg_w[sel];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] o);
    op     = o;
    start  = 1'b1;
    m_pass = 0;
    m_fail = 0;
    m_ev   = 1'b0;
    m_ea   = '0;
    m_eb   = '0;
    m_ee   = '0;
    m_eg   = '0;
    sb.delete();
    tick();
    start = 1'b0;
  endtask

  // A counted vector's effect on the registered counters is visible LAT+1 edges after it is driven.
  task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] m,
                       input logic v, input logic cnt);
    rec_t r;
    a        = x;
    b        = y;
    mask     = m;
    in_valid = v;
    if (cnt) begin
      r.due = cyc + 1 + lat_of(sel);
      r.ok  = (m == '0);
      r.a   = x;
      r.b   = y;
      r.e   = ref_op(op, x, y);
      r.g   = r.e ^ m;
      sb.push_back(r);
    end
    last_cyc = cyc;
    tick();
    in_valid = 1'b0;
    mask     = '0;
  endtask

  task automatic wait_done(output int dcyc);
    dcyc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done_s === 1'b1) begin
        dcyc = cyc;
        break;
      end
    end
    checks++;
    if (dcyc < 0) begin
      errors++;
      $display("FAIL done_timeout inst=%0d: done not seen within 100 cycles", sel);
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (busy_w[i] !== 1'b0 || done_w[i] !== 1'b0 || errv_w[i] !== 1'b0 || pass_w[i] !== 16'd0 ||
          fail_w[i] !== 16'd0 || ea_w[i] !== '0 || eb_w[i] !== '0 || ee_w[i] !== '0 || eg_w[i] !== '0) begin
        errors++;
        $display("FAIL reset_state inst=%0d: busy=%b done=%b err_valid=%b pass=%0d fail=%0d, required all 0",
                 i, busy_w[i], done_w[i], errv_w[i], pass_w[i], fail_w[i]);
      end
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_or_lat0();
    logic [W-1:0] vals [3];
    int           dc;
    vals = '{32'h0, 32'h11111111, 32'hFFFFFFFF};
    sel  = 0;
    do_start(2'b01);
    checks++;
    if (busy_s !== 1'b1) begin
      errors++;
      $display("FAIL or_lat0_busy: busy=%b, required 1", busy_s);
    end
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        drive(vals[i], vals[j], '0, 1'b1, 1'b1);
    wait_done(dc);
    checks++;
    if (pass_s !== 16'd9 || fail_s !== 16'd0 || errv_s !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL or_lat0_final: pass=%0d fail=%0d err_valid=%b pending=%0d, required 9/0/0/0",
               pass_s, fail_s, errv_s, sb.size());
    end
    repeat (8) tick();
  endtask

  task automatic test_or_lat2_fault();
    logic [W-1:0] vals [3];
    int           dc;
    vals = '{32'h0, 32'h11111111, 32'hFFFFFFFF};
    sel  = 1;
    do_start(2'b01);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        drive(vals[i], vals[j], (vals[i] == 32'h11111111 && vals[j] == 32'h0) ? 32'h1 : 32'h0, 1'b1, 1'b1);
    wait_done(dc);
    checks++;
    if (dc != last_cyc + 1 + 2) begin
      errors++;
      $display("FAIL lat2_done_timing: done at cycle %0d, required %0d", dc, last_cyc + 3);
    end
    checks++;
    if (pass_s !== 16'd8 || fail_s !== 16'd1 || errv_s !== 1'b1) begin
      errors++;
      $display("FAIL lat2_counts: pass=%0d fail=%0d err_valid=%b, required 8/1/1", pass_s, fail_s, errv_s);
    end
    checks++;
    if (ea_s !== 32'h11111111 || eb_s !== 32'h0 || ee_s !== 32'h11111111 || eg_s !== 32'h11111110) begin
      errors++;
      $display("FAIL lat2_capture: a=%h b=%h exp=%h got=%h, required 11111111/00000000/11111111/11111110",
               ea_s, eb_s, ee_s, eg_s);
    end
    repeat (8) tick();
  endtask

  task automatic test_and_first_error();
    logic [W-1:0] x, y, a3, b3, m;
    int           dc;
    a3  = '0;
    b3  = '0;
    sel = 2;
    do_start(2'b00);
    for (int i = 1; i <= 9; i++) begin
      x = $urandom | 32'h0000_0101;
      y = $urandom | 32'h0000_0101;
      m = (i == 3) ? 32'h0000_0001 : (i == 5) ? 32'h0000_0100 : (i == 7) ? 32'h8000_0000 : 32'h0;
      if (i == 3) begin
        a3 = x;
        b3 = y;
      end
      drive(x, y, m, 1'b1, 1'b1);
    end
    wait_done(dc);
    checks++;
    if (fail_s !== 16'd3 || pass_s !== 16'd6) begin
      errors++;
      $display("FAIL and_counts: pass=%0d fail=%0d, required 6/3", pass_s, fail_s);
    end
    checks++;
    if (ea_s !== a3 || eb_s !== b3 || ee_s !== (a3 & b3) || eg_s !== ((a3 & b3) ^ 32'h1)) begin
      errors++;
      $display("FAIL and_first_capture: a=%h b=%h exp=%h got=%h, required %h %h %h %h",
               ea_s, eb_s, ee_s, eg_s, a3, b3, a3 & b3, (a3 & b3) ^ 32'h1);
    end
    repeat (8) tick();
  endtask

  task automatic test_back_to_back();
    int dc;
    sel = 3;
    do_start(2'b01);
    for (int i = 0; i < 9; i++) begin
      drive($urandom, $urandom, '0, 1'b1, 1'b1);
      start = (i == 3);
      drive($urandom, $urandom, '0, 1'b0, 1'b0);
      start = 1'b0;
      if (i == 3) begin
        checks++;
        if (busy_s !== 1'b1) begin
          errors++;
          $display("FAIL ignored_start_busy: busy=%b, required 1", busy_s);
        end
      end
    end
    wait_done(dc);
    for (int i = 0; i < 3; i++) drive($urandom, $urandom, 32'hFFFF_FFFF, 1'b1, 1'b0);
    repeat (4) tick();
    checks++;
    if (pass_s !== 16'd9 || fail_s !== 16'd0 || done_s !== 1'b1 || sb.size() != 0) begin
      errors++;
      $display("FAIL lat3_hold: pass=%0d fail=%0d done=%b pending=%0d, required 9/0/1/0",
               pass_s, fail_s, done_s, sb.size());
    end
    repeat (8) tick();
  endtask

  task automatic test_reset_in_drain();
    int dc;
    sel = 1;
    do_start(2'b10);
    for (int i = 0; i < 9; i++) drive($urandom, $urandom, '0, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy_s !== 1'b0 || done_s !== 1'b0 || pass_s !== 16'd0 || fail_s !== 16'd0 || errv_s !== 1'b0 ||
        ea_s !== '0 || eb_s !== '0 || ee_s !== '0 || eg_s !== '0) begin
      errors++;
      $display("FAIL async_reset: busy=%b done=%b pass=%0d fail=%0d err_valid=%b, required all 0",
               busy_s, done_s, pass_s, fail_s, errv_s);
    end
    sb.delete();
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy_s !== 1'b0 || done_s !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: busy=%b done=%b, required 0/0", busy_s, done_s);
    end
    do_start(2'b10);
    for (int i = 0; i < 9; i++) drive($urandom, $urandom, '0, 1'b1, 1'b1);
    wait_done(dc);
    checks++;
    if (pass_s !== 16'd9 || fail_s !== 16'd0) begin
      errors++;
      $display("FAIL rerun_after_reset: pass=%0d fail=%0d, required 9/0", pass_s, fail_s);
    end
    repeat (8) tick();
  endtask

  task automatic test_single_nor();
    int dc;
    sel = 4;
    do_start(2'b11);
    drive(32'h0, 32'h0, '0, 1'b1, 1'b1);
    wait_done(dc);
    checks++;
    if (dc != last_cyc + 1) begin
      errors++;
      $display("FAIL nor_done_timing: done at cycle %0d, required %0d", dc, last_cyc + 1);
    end
    checks++;
    if (pass_s !== 16'd1 || fail_s !== 16'd0 || errv_s !== 1'b0) begin
      errors++;
      $display("FAIL nor_single: pass=%0d fail=%0d err_valid=%b, required 1/0/0", pass_s, fail_s, errv_s);
    end
    repeat (4) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    fork
      begin : sb_monitor
        rec_t r;
        forever begin
          @(negedge clk);
          if (sb.size() > 0 && sb[0].due == cyc) begin
            r = sb.pop_front();
            if (r.ok) begin
              m_pass++;
            end else begin
              m_fail++;
              if (!m_ev) begin
                m_ev = 1'b1;
                m_ea = r.a;
                m_eb = r.b;
                m_ee = r.e;
                m_eg = r.g;
              end
            end
            checks++;
            if (pass_s !== 16'(m_pass) || fail_s !== 16'(m_fail)) begin
              errors++;
              $display("FAIL sb_counts inst=%0d cyc=%0d: pass=%0d fail=%0d, required %0d/%0d",
                       sel, cyc, pass_s, fail_s, m_pass, m_fail);
            end
            checks++;
            if (errv_s !== m_ev || ea_s !== m_ea || eb_s !== m_eb || ee_s !== m_ee || eg_s !== m_eg) begin
              errors++;
              $display("FAIL sb_capture inst=%0d cyc=%0d: v=%b a=%h b=%h e=%h g=%h, required %b %h %h %h %h",
                       sel, cyc, errv_s, ea_s, eb_s, ee_s, eg_s, m_ev, m_ea, m_eb, m_ee, m_eg);
            end
          end
        end
      end
    join_none

    test_reset();
    test_or_lat0();
    test_or_lat2_fault();
    test_and_first_error();
    test_back_to_back();
    test_reset_in_drain();
    test_single_nor();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
